// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: register address, data word
// and the buffered long-latency result entry.
package regfile_wport_arbiter_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_addr_t waddr;
        word_t     wdata;
    } lu_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_mask(input reg_addr_t addr);
        logic [NUM_REGS-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_fifo.sv
// wb_result_fifo: small FIFO of returned long-latency results with wrap-around
// pointers and an occupancy count.
module wb_result_fifo
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  lu_entry_t                    push_data,
    input  logic                         pop,
    output lu_entry_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    lu_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the regfile write port between W-stage writeback and buffered long-latency
// results, and scoreboards pending destinations. Optional macro: RF_ARB_FORCE_DRAIN_EN.
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        lu_issue_valid,
    input  logic [4:0]  lu_issue_waddr,
    output logic        lu_issue_ready,
    input  logic        lu_res_valid,
    input  logic [4:0]  lu_res_waddr,
    input  logic [31:0] lu_res_wdata,
    output logic        lu_res_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    input  logic        weD,
    input  logic [4:0]  waddrD,
    output logic        stall_reqD_busy,
    output logic        stall_reqW_drain
);

    localparam int OUT_W = $clog2(FIFO_DEPTH + 1);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pend_eff;
    logic [NUM_REGS-1:0] pending_next;
    logic [OUT_W-1:0]    outstanding;

    lu_entry_t           head;
    lu_entry_t           res_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic [OUT_W-1:0]    unused_fifo_count;

    logic                w_owns;
    logic                issue;
    logic                push;
    logic                pop;

    assign w_owns         = wb_we && (wb_waddr != '0);
    assign lu_issue_ready = (outstanding < OUT_W'(FIFO_DEPTH));
    assign lu_res_ready   = !fifo_full;
    assign issue          = lu_issue_valid && lu_issue_ready;
    assign push           = lu_res_valid && lu_res_ready;
    assign pop            = !fifo_empty && !w_owns;
    assign res_entry      = '{waddr: lu_res_waddr, wdata: lu_res_wdata};

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (res_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_fifo_count)
    );

    // A popped result to $0 is retired silently.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_owns) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end else if (pop && (head.waddr != '0)) begin
            rf_we    = 1'b1;
            rf_waddr = head.waddr;
            rf_wdata = head.wdata;
        end
    end

    // The register being written this cycle is served by the regfile W bypass.
    always_comb begin
        pend_eff     = pending & ~(pop ? reg_mask(head.waddr) : '0);
        pending_next = pend_eff;
        if (issue && (lu_issue_waddr != '0)) pending_next = pending_next | reg_mask(lu_issue_waddr);
    end

    assign stall_reqD_busy = (re1 && (raddr1 != '0) && pend_eff[raddr1])
                          || (re2 && (raddr2 != '0) && pend_eff[raddr2])
                          || (weD && pend_eff[waddrD]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= '0;
            outstanding <= '0;
        end else begin
            pending <= pending_next;
            case ({issue, pop})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef RF_ARB_FORCE_DRAIN_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;

    assign stall_reqW_drain = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Clearing on the drain pulse itself keeps it single-cycle even if W is not frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (pop || stall_reqW_drain) begin
            starve_cnt <= '0;
        end else if (!fifo_empty && w_owns) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
`else
    logic unused_starve_limit;

    assign unused_starve_limit = ^STARVE_LIMIT;
    assign stall_reqW_drain    = 1'b0;
`endif

endmodule

// File: doc/regfile_wport_arbiter.md
# regfile_wport_arbiter

Write-port arbiter and scoreboard for the single regfile write port. It shares the port between the in-order pipeline writeback (W stage) and a long-latency unit (mul/div and similar) whose results return out of order with respect to the pipeline. It holds returned results in a small FIFO and drains them into idle write slots. It tracks pending destinations so decode stalls on RAW/WAW hazards against in-flight long-latency results. It sits between W stage, the long-latency unit and `regfile`, alongside the existing load-use stall logic.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: result buffer entries; also the maximum number of outstanding long-latency ops.
- `STARVE_LIMIT`, 4: consecutive blocked cycles before a forced drain (used only under the macro).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wb_we` / `wb_waddr` / `wb_wdata`  in  1/5/32  W-stage write; highest priority, never back-pressured.
- `lu_issue_valid` / `lu_issue_waddr`  in  1/5  long-latency op leaving E with its destination.
- `lu_issue_ready`  out  1  outstanding count < `FIFO_DEPTH`.
- `lu_res_valid` / `lu_res_waddr` / `lu_res_wdata`  in  1/5/32  returned result.
- `lu_res_ready`  out  1  FIFO not full.
- `rf_we` / `rf_waddr` / `rf_wdata`  out  1/5/32  to regfile write port.
- `re1`, `raddr1`, `re2`, `raddr2`, `weD`, `waddrD`  in  1/5 each  decode source and destination registers.
- `stall_reqD_busy`  out  1  decode hazard on a pending register.
- `stall_reqW_drain`  out  1  freeze W one cycle (only with the macro; tied 0 otherwise).

## Operation
- Issue: handshake `lu_issue_valid && lu_issue_ready` with `lu_issue_waddr != 0` sets `pending[waddr]` and increments `outstanding`. Issue to $0 increments `outstanding` only.
- Accept: handshake `lu_res_valid && lu_res_ready` pushes {waddr, wdata} into the FIFO.
- Port select, per cycle:
  - If `wb_we && wb_waddr != 0`, the port drives the W data.
  - Otherwise, if the FIFO is non-empty, pop the head and drive it.
  - Otherwise `rf_we = 0`.
  - A FIFO pop clears `pending[head.waddr]` and decrements `outstanding`.
- Decode hazard: `stall_reqD_busy` = (`re1 && raddr1 != 0 && pend_eff[raddr1]`) OR the same for `re2`/`raddr2` OR (`weD && pend_eff[waddrD]`).
  - `pend_eff` is `pending` with the bit of a same-cycle FIFO pop masked off. The regfile W bypass supplies that data.
- At most one outstanding op per destination register, because decode stalls on WAW. Issuing to a register whose pending bit is already set is illegal; bench asserts it never happens.
- Simultaneous issue and pop: `outstanding` is unchanged; set and clear of different bits both apply.
- Results to $0 are popped without asserting `rf_we`.

## Timing
- Reset values: FIFO empty, `outstanding` 0, `pending` all 0, starve counter 0, `lu_issue_ready` 1, `lu_res_ready` 1, `stall_reqD_busy` 0, `stall_reqW_drain` 0. `rf_*` are combinational and follow the W inputs, else 0.
- A result accepted in cycle N is written no earlier than N+1. Minimum latency is exactly 1 when W is idle in N+1.
- `stall_reqD_busy` drops combinationally in the cycle the pending result is written.
- Reset mid-operation discards the FIFO and scoreboard immediately.

## Configuration
- `RF_ARB_FORCE_DRAIN_EN` defined:
  - A counter increments each cycle the FIFO is non-empty and W owns the port; it clears on any pop.
  - When the count reaches `STARVE_LIMIT`, assert `stall_reqW_drain` for exactly one cycle. The hazard unit freezes W, so `wb_we` is 0, and the head pops.
  - The counter then clears.
- Undefined: no counter; `stall_reqW_drain` is tied 0. The FIFO drains only in natural W bubbles, and `lu_issue_ready` provides the back-pressure.

## Structure
- Shared package (`my_mips.svh`): `lu_entry_t` struct {`reg_addr_t waddr; word_t wdata;`}. The existing `reg_addr_t` and `word_t` are reused.
- Sub-module `wb_result_fifo`: parameterised-depth FIFO of `lu_entry_t` with push/pop/full/empty and wrap-around pointers plus a count. The arbiter instantiates one.

## Test plan
- Issue to $8, result 0xDEAD_BEEF returns with W idle: `rf_we` at N+1 with $8 = 0xDEADBEEF. Decode read of $8 stalls until that cycle, then proceeds with the bypassed value.
- Result for $9 returns while W writes $3 for 3 cycles: $3 writes occur back-to-back, then $9 is written in the first idle cycle. FIFO order is preserved for a second queued $10.
- Two issues with `FIFO_DEPTH` = 2: `lu_issue_ready` = 0 until the first pop; a third issue is held.
- Decode with `weD` = 1, `waddrD` = $8 while $8 is pending: stall asserted. With `re1` on $0: no stall.
- Macro on, `STARVE_LIMIT` 4, W writes every cycle, one FIFO entry: `stall_reqW_drain` pulses on cycle 4, the entry is written, and the counter resets.
- Assert `rst` low with 2 entries queued: FIFO empty, `pending` 0, and nothing is written after release.
